// File: rtl/int8_simd_mac_unit.sv
// int8_simd_mac_unit: packed INT8 dot-product / multiply-accumulate unit for
// the coprocessor path. Decoded ops enter through a credit-checked issue port,
// travel down a fixed-latency pipeline and land, in issue order, in a result
// FIFO that drains to the result channel under ready/valid backpressure.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   issue_*_i / _o         op, accumulator select, signed/sat modes, operands, tags
//   result_*_o / _i        FIFO head: data, id, hartid, rd, we; consumer ready
//   busy_o                 any op in the pipeline or the FIFO
module int8_simd_mac_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NrAcc       = 4,
    parameter int unsigned AccWidth    = 32,
    parameter int unsigned PipeStages  = 2,
    parameter int unsigned FifoDepth   = 4,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned HartidWidth = 1,
    localparam int unsigned SelW       = (NrAcc > 1) ? $clog2(NrAcc) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [2:0]             op_i,
    input  logic [SelW-1:0]        acc_sel_i,
    input  logic                   signed_i,
    input  logic                   sat_i,
    input  logic [XLEN-1:0]        rs1_i,
    input  logic [XLEN-1:0]        rs2_i,
    input  logic [IdWidth-1:0]     id_i,
    input  logic [HartidWidth-1:0] hartid_i,
    input  logic [4:0]             rd_addr_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [XLEN-1:0]        result_data_o,
    output logic [IdWidth-1:0]     result_id_o,
    output logic [HartidWidth-1:0] result_hartid_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o,
    output logic                   busy_o
);

    localparam int unsigned Lanes = XLEN / 8;
    localparam int unsigned SumW  = 18 + $clog2(Lanes) + 1;
    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned CntW  = $clog2(FifoDepth + 1);

    localparam logic [2:0] OpDot    = 3'd0;
    localparam logic [2:0] OpMac    = 3'd1;
    localparam logic [2:0] OpClr    = 3'd2;
    localparam logic [2:0] OpRdAcc  = 3'd3;
    localparam logic [2:0] OpSetAcc = 3'd4;

    typedef struct packed {
        logic                   valid;
        logic [2:0]             op;
        logic [SelW-1:0]        sel;
        logic                   sat;
        logic [XLEN-1:0]        rs1;
        logic [AccWidth-1:0]    dot;
        logic [IdWidth-1:0]     id;
        logic [HartidWidth-1:0] hartid;
        logic [4:0]             rd;
    } pipe_t;

    typedef struct packed {
        logic [XLEN-1:0]        data;
        logic [IdWidth-1:0]     id;
        logic [HartidWidth-1:0] hartid;
        logic [4:0]             rd;
        logic                   we;
    } res_t;

    logic                accept_c;
    logic                pop_c;
    logic signed [SumW-1:0] sum_c;
    pipe_t               issue_c;
    pipe_t               fin_c;
    res_t                res_c;

    logic [AccWidth-1:0] acc_q [NrAcc];
    logic [AccWidth-1:0] acc_d [NrAcc];
    res_t                fifo_q [FifoDepth];
    res_t                fifo_d [FifoDepth];
    logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]     occ_q, occ_d;     // FIFO occupancy
    logic [CntW-1:0]     cnt_q, cnt_d;     // ops in pipeline + FIFO (credits used)
    logic                ready_q, ready_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : PtrW'(p + 1'b1);
    endfunction

    assign accept_c = issue_valid_i & ready_q;
    assign pop_c    = result_valid_o & result_ready_i;

    // Lane-wise products, each operand widened to 9 bits so signed and
    // unsigned lanes share one signed multiplier.
    always_comb begin
        logic signed [8:0]  a9;
        logic signed [8:0]  b9;
        logic signed [17:0] prod;
        sum_c = '0;
        a9    = '0;
        b9    = '0;
        prod  = '0;
        for (int unsigned i = 0; i < Lanes; i++) begin
            a9    = {signed_i & rs1_i[8*i+7], rs1_i[8*i +: 8]};
            b9    = {signed_i & rs2_i[8*i+7], rs2_i[8*i +: 8]};
            prod  = a9 * b9;
            sum_c = sum_c + SumW'(prod);
        end
    end

    // Issue payload; the dot product is formed here and carried down the pipe.
    always_comb begin
        issue_c        = '0;
        issue_c.valid  = accept_c;
        issue_c.op     = op_i;
        issue_c.sel    = acc_sel_i;
        issue_c.sat    = sat_i;
        issue_c.rs1    = rs1_i;
        issue_c.dot    = AccWidth'(sum_c);
        issue_c.id     = id_i;
        issue_c.hartid = hartid_i;
        issue_c.rd     = rd_addr_i;
    end

    // PipeStages-1 register stages; the FIFO entry is the last stage.
    if (PipeStages == 1) begin : g_nopipe
        assign fin_c = issue_c;
    end else begin : g_pipe
        pipe_t stage_q [PipeStages-1];
        pipe_t stage_d [PipeStages-1];

        always_comb begin
            stage_d[0] = issue_c;
            for (int unsigned k = 1; k < PipeStages - 1; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int unsigned k = 0; k < PipeStages - 1; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign fin_c = stage_q[PipeStages-2];
    end

    // Final stage: all accumulator reads and writes happen here, in issue order.
    always_comb begin
        logic [SelW-1:0]     sel;
        logic [AccWidth-1:0] cur;
        logic [AccWidth:0]   msum;
        logic [AccWidth-1:0] mac;
        acc_d      = acc_q;
        res_c      = '0;
        res_c.id     = fin_c.id;
        res_c.hartid = fin_c.hartid;
        res_c.rd     = fin_c.rd;
        sel  = fin_c.sel & SelW'(NrAcc - 1);
        cur  = acc_q[sel];
        msum = {cur[AccWidth-1], cur} + {fin_c.dot[AccWidth-1], fin_c.dot};
        // Signed overflow shows as disagreement of the two top sum bits.
        if (fin_c.sat && (msum[AccWidth] != msum[AccWidth-1])) begin
            mac = msum[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                 : {1'b0, {(AccWidth-1){1'b1}}};
        end else begin
            mac = msum[AccWidth-1:0];
        end
        if (fin_c.valid) begin
            case (fin_c.op)
                OpDot: begin
                    res_c.data = fin_c.dot[XLEN-1:0];
                    res_c.we   = 1'b1;
                end
                OpMac: begin
                    acc_d[sel] = mac;
                    res_c.data = mac[XLEN-1:0];
                    res_c.we   = 1'b1;
                end
                OpClr:    acc_d[sel] = '0;
                OpRdAcc: begin
                    res_c.data = cur[XLEN-1:0];
                    res_c.we   = 1'b1;
                end
                OpSetAcc: acc_d[sel] = AccWidth'($signed(fin_c.rs1));
                default: ;
            endcase
        end
    end

    // Result FIFO and credit bookkeeping.
    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (fin_c.valid) begin
            fifo_d[wptr_q] = res_c;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop_c) begin
            rptr_d = ptr_inc(rptr_q);
        end
        occ_d   = occ_q + CntW'(fin_c.valid) - CntW'(pop_c);
        cnt_d   = cnt_q + CntW'(accept_c) - CntW'(pop_c);
        ready_d = (cnt_d < CntW'(FifoDepth));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned a = 0; a < NrAcc; a++) begin
                acc_q[a] <= '0;
            end
            for (int unsigned e = 0; e < FifoDepth; e++) begin
                fifo_q[e] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            fifo_q  <= fifo_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign issue_ready_o   = ready_q;
    assign busy_o          = (cnt_q != '0);
    assign result_valid_o  = (occ_q != '0);
    assign result_data_o   = fifo_q[rptr_q].data;
    assign result_id_o     = fifo_q[rptr_q].id;
    assign result_hartid_o = fifo_q[rptr_q].hartid;
    assign result_rd_o     = fifo_q[rptr_q].rd;
    assign result_we_o     = fifo_q[rptr_q].we;

endmodule

// File: tb/tb_int8_simd_mac_unit.sv
// Testbench for int8_simd_mac_unit with default parameters.
module tb_int8_simd_mac_unit;

    localparam logic [2:0] OP_DOT = 3'd0, OP_MAC = 3'd1, OP_CLR = 3'd2,
                           OP_RD  = 3'd3, OP_SET = 3'd4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [2:0]  op_i;
    logic [1:0]  acc_sel_i;
    logic        signed_i;
    logic        sat_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [3:0]  id_i;
    logic [0:0]  hartid_i;
    logic [4:0]  rd_addr_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_data_o;
    logic [3:0]  result_id_o;
    logic [0:0]  result_hartid_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    int_dummy_guard u_guard_unused();

    int8_simd_mac_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .op_i(op_i), .acc_sel_i(acc_sel_i), .signed_i(signed_i), .sat_i(sat_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .id_i(id_i), .hartid_i(hartid_i),
        .rd_addr_i(rd_addr_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_data_o(result_data_o), .result_id_o(result_id_o),
        .result_hartid_o(result_hartid_o), .result_rd_o(result_rd_o),
        .result_we_o(result_we_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  sel;
        logic        sgn;
        logic        sat;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [1:0] sel, input logic sgn,
                          input logic sat, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] id, input logic [4:0] rd);
        op_i = op; acc_sel_i = sel; signed_i = sgn; sat_i = sat;
        rs1_i = a; rs2_i = b; id_i = id; hartid_i = id[0]; rd_addr_i = rd;
    endtask

    // Offer the current op until accepted (bounded).
    task automatic offer(input string name);
        int n = 0;
        issue_valid_i = 1'b1;
        while (!issue_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!issue_ready_o) begin
            checks++; errors++;
            $display("FAIL %s: issue_ready_o never asserted", name);
        end
        tick();
        issue_valid_i = 1'b0;
    endtask

    // Wait for a result (bounded), compare it, and let it pop.
    task automatic expect_res(input string name, input logic [31:0] data, input logic we,
                              input logic [3:0] id, input logic [4:0] rd);
        int n = 0;
        while (!result_valid_o && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, 32'(result_valid_o), 32'd1);
        chk({name, "_data"}, result_data_o, data);
        chk({name, "_we"}, 32'(result_we_o), 32'(we));
        chk({name, "_tag"}, {22'd0, result_hartid_o, result_id_o, result_rd_o},
            {22'd0, id[0], id, rd});
        tick();
    endtask

    initial begin
        logic [31:0] got_data [$];
        int          got_cyc [$];
        logic [3:0]  got_id [$];
        int          nacc;
        logic        r;
        logic [31:0] h_data;
        logic [3:0]  h_id;

        vecs[0]  = '{OP_RD,  2'd1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h000000D2, 1'b1};
        vecs[1]  = '{OP_RD,  2'd0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1};
        vecs[2]  = '{OP_DOT, 2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h02020202, 32'hFFFFFFF8, 1'b1};
        vecs[3]  = '{OP_DOT, 2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h02020202, 32'h000007F8, 1'b1};
        vecs[4]  = '{OP_SET, 2'd2, 1'b1, 1'b0, 32'h7FFFFFF0, 32'h0,        32'h00000000, 1'b0};
        vecs[5]  = '{OP_MAC, 2'd2, 1'b1, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFFF, 1'b1};
        vecs[6]  = '{OP_SET, 2'd2, 1'b1, 1'b0, 32'h7FFFFFF0, 32'h0,        32'h00000000, 1'b0};
        vecs[7]  = '{OP_MAC, 2'd2, 1'b1, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h8000FBF4, 1'b1};
        vecs[8]  = '{OP_RD,  2'd2, 1'b1, 1'b0, 32'h0,        32'h0,        32'h8000FBF4, 1'b1};
        vecs[9]  = '{OP_CLR, 2'd2, 1'b1, 1'b0, 32'h12345678, 32'h0,        32'h00000000, 1'b0};
        vecs[10] = '{OP_RD,  2'd2, 1'b1, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{OP_SET, 2'd3, 1'b1, 1'b0, 32'h80000000, 32'h0,        32'h00000000, 1'b0};
        vecs[12] = '{OP_MAC, 2'd3, 1'b1, 1'b1, 32'h80808080, 32'h7F7F7F7F, 32'h80000000, 1'b1};
        vecs[13] = '{OP_MAC, 2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0003F804, 1'b1};
        vecs[14] = '{3'd5,   2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[15] = '{OP_RD,  2'd0, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0003F804, 1'b1};
        vecs[16] = '{OP_DOT, 2'd0, 1'b1, 1'b0, 32'h80808080, 32'h80808080, 32'h00010000, 1'b1};
        vecs[17] = '{OP_SET, 2'd3, 1'b1, 1'b0, 32'hFFFFFFF0, 32'h0,        32'h00000000, 1'b0};
        vecs[18] = '{OP_MAC, 2'd3, 1'b1, 1'b0, 32'h01010101, 32'h02020202, 32'hFFFFFFF8, 1'b1};
        vecs[19] = '{3'd7,   2'd1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};

        rst_i = 1'b1; issue_valid_i = 1'b0; result_ready_i = 1'b1;
        set_op(OP_DOT, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0, 5'd0);
        repeat (3) tick();

        // Reset state
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(issue_ready_o), 32'd0);
        chk("rst_data", result_data_o, 32'd0);
        chk("rst_tag", {26'd0, result_we_o, result_id_o, result_hartid_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_ready", 32'(issue_ready_o), 32'd1);

        // Latency: result visible exactly two cycles after the issue cycle
        set_op(OP_DOT, 2'd0, 1'b1, 1'b0, 32'h01020304, 32'h05060708, 4'd9, 5'd7);
        issue_valid_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        chk("lat_early_valid", 32'(result_valid_o), 32'd0);
        chk("lat_busy", 32'(busy_o), 32'd1);
        tick();
        chk("lat_valid", 32'(result_valid_o), 32'd1);
        chk("lat_data", result_data_o, 32'h00000046);
        chk("lat_we", 32'(result_we_o), 32'd1);
        chk("lat_id", 32'(result_id_o), 32'd9);
        tick();
        chk("lat_drained_valid", 32'(result_valid_o), 32'd0);
        chk("lat_drained_busy", 32'(busy_o), 32'd0);

        // Three back-to-back MACs to acc1
        for (int k = 0; k < 10; k++) begin
            if (result_valid_o) begin
                got_data.push_back(result_data_o);
                got_cyc.push_back(k);
            end
            if (k < 3) begin
                set_op(OP_MAC, 2'd1, 1'b1, 1'b0, 32'h01020304, 32'h05060708, 4'(k), 5'd1);
                issue_valid_i = 1'b1;
            end else begin
                issue_valid_i = 1'b0;
            end
            tick();
        end
        chk("mac3_count", 32'(got_data.size()), 32'd3);
        if (got_data.size() == 3) begin
            chk("mac3_r0", got_data[0], 32'h46);
            chk("mac3_r1", got_data[1], 32'h8C);
            chk("mac3_r2", got_data[2], 32'hD2);
            chk("mac3_consec", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
        end

        // Table-driven single ops
        for (int i = 0; i < NV; i++) begin
            set_op(vecs[i].op, vecs[i].sel, vecs[i].sgn, vecs[i].sat,
                   vecs[i].rs1, vecs[i].rs2, 4'(i), 5'(i + 3));
            offer($sformatf("vec%0d", i));
            expect_res($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_we,
                       4'(i), 5'(i + 3));
        end

        // Backpressure: four credits, head held, in-order drain
        result_ready_i = 1'b0;
        nacc = 0;
        set_op(OP_DOT, 2'd0, 1'b0, 1'b0, 32'd1, 32'h01, 4'd0, 5'd2);
        issue_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            r = issue_ready_o;
            tick();
            if (r) nacc++;
            set_op(OP_DOT, 2'd0, 1'b0, 1'b0, 32'(nacc + 1), 32'h01, 4'(nacc), 5'd2);
        end
        issue_valid_i = 1'b0;
        chk("bp_accepts", 32'(nacc), 32'd4);
        chk("bp_ready_low", 32'(issue_ready_o), 32'd0);
        h_data = result_data_o;
        h_id   = result_id_o;
        chk("bp_head_id", 32'(h_id), 32'd0);
        chk("bp_head_data", h_data, 32'd1);
        tick(); tick();
        chk("bp_hold_valid", 32'(result_valid_o), 32'd1);
        chk("bp_hold_id", 32'(result_id_o), 32'd0);
        chk("bp_hold_data", result_data_o, 32'd1);
        result_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (result_valid_o) got_id.push_back(result_id_o);
            tick();
            if (k == 0) chk("bp_ready_reassert", 32'(issue_ready_o), 32'd1);
        end
        chk("bp_pop_count", 32'(got_id.size()), 32'd4);
        for (int k = 0; k < 4 && k < got_id.size(); k++) begin
            chk($sformatf("bp_pop%0d_id", k), 32'(got_id[k]), 32'(k));
        end

        // Reset with ops in flight and queued
        result_ready_i = 1'b0;
        set_op(OP_SET, 2'd0, 1'b1, 1'b0, 32'h11, 32'h0, 4'd1, 5'd1);
        issue_valid_i = 1'b1;
        tick();
        set_op(OP_SET, 2'd1, 1'b1, 1'b0, 32'h22, 32'h0, 4'd2, 5'd1);
        tick();
        set_op(OP_MAC, 2'd2, 1'b1, 1'b0, 32'h01010101, 32'h01010101, 4'd3, 5'd1);
        chk("mid_busy", 32'(busy_o), 32'd1);
        chk("mid_valid", 32'(result_valid_o), 32'd1);
        rst_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        chk("mid_rst_ready", 32'(issue_ready_o), 32'd0);
        chk("mid_rst_valid", 32'(result_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        result_ready_i = 1'b1;
        r = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            r = r | result_valid_o | busy_o;
        end
        chk("post_rst_quiet", 32'(r), 32'd0);
        for (int a = 0; a < 4; a++) begin
            set_op(OP_RD, 2'(a), 1'b1, 1'b0, 32'h0, 32'h0, 4'(a + 8), 5'(a));
            offer($sformatf("rst_rd%0d", a));
            expect_res($sformatf("rst_rd%0d", a), 32'd0, 1'b1, 4'(a + 8), 5'(a));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// Empty helper module local to the bench.
module int_dummy_guard;
endmodule

// File: doc/int8_simd_mac_unit.md
Name: int8_simd_mac_unit

Overview:
Second-generation INT8 execution unit for the CVXIF coprocessor path. It is parametrised in lane count (XLEN/8 packed INT8 lanes) and in the number of architectural accumulators. It adds signed/unsigned and saturating/wrapping modes, a configurable pipeline depth, and an in-order result FIFO with ready/valid backpressure. It sits behind the coprocessor decoder. It accepts decoded ops with operands and returns tagged results (id, hartid, rd, we) to the CVXIF result channel.

Parameters:
XLEN, 32, operand/result width; must be a multiple of 8; Lanes = XLEN/8 (derived).
NrAcc, 4, number of accumulator registers (power of 2, >=1).
AccWidth, 32, accumulator width; must be >= XLEN.
PipeStages, 2, issue-to-writeback pipeline depth (>=1).
FifoDepth, 4, result FIFO entries (>=2).
IdWidth, 4, instruction id width.
HartidWidth, 1, hart id width.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_i  in  1  reset: synchronous, active-high.
issue_valid_i  in  1  op offered.
issue_ready_o  out  1  op accepted when valid&ready.
op_i  in  3  0=DOT, 1=MAC, 2=CLR, 3=RDACC, 4=SETACC, 5-7=illegal.
acc_sel_i  in  max(1,$clog2(NrAcc))  accumulator index.
signed_i  in  1  1 = lanes are signed INT8, 0 = unsigned.
sat_i  in  1  1 = MAC saturates, 0 = MAC wraps.
rs1_i  in  XLEN  packed lanes A / SETACC value.
rs2_i  in  XLEN  packed lanes B.
id_i  in  IdWidth  instruction tag.
hartid_i  in  HartidWidth  hart tag.
rd_addr_i  in  5  destination register.
result_valid_o  out  1  FIFO head valid.
result_ready_i  in  1  consumer pops head when valid&ready.
result_data_o  out  XLEN  result value.
result_id_o  out  IdWidth  tag of head.
result_hartid_o  out  HartidWidth  hart of head.
result_rd_o  out  5  rd of head.
result_we_o  out  1  register write enable of head.
busy_o  out  1  any op in pipeline or FIFO.

Behaviour:
- Reset (rst_i high at a clock edge): all accumulators cleared to 0; pipeline flushed; FIFO emptied; result_valid_o=0, result_*_o=0, busy_o=0.
- issue_ready_o=0 while rst_i is high. Reset mid-operation discards in-flight ops and queued results; none are returned.
- Credit rule: issue_ready_o = (ops in pipeline + FIFO occupancy) < FifoDepth. An accepted op is therefore never dropped and the pipeline never stalls.
- issue_ready_o depends only on registered state, never on issue_valid_i.
- Dot product: lane i = bits [8i+7:8i]. Each lane product is sign- or zero-extended per signed_i. dot = sum of Lanes products, extended to AccWidth.
- All ops act on the accumulators at the final stage, in issue order. Back-to-back MACs to the same accumulator therefore see each other's results with no stall or hazard.
- Per-op results:
  - DOT: data = dot[XLEN-1:0], we=1, accumulators unchanged.
  - MAC: acc[sel] = acc[sel]+dot. With sat_i=1, the sum clamps to the signed AccWidth range [-2^(AccWidth-1), 2^(AccWidth-1)-1]. With sat_i=0, it wraps mod 2^AccWidth. data = new acc[XLEN-1:0], we=1.
  - CLR: acc[sel]=0, data=0, we=0.
  - RDACC: data = acc[sel][XLEN-1:0], we=1, no change.
  - SETACC: acc[sel] = sign-extended rs1_i, data=0, we=0.
  - Illegal op: no state change, data=0, we=0.
- Every accepted op yields exactly one result entry, returned in issue order. id, hartid and rd are carried through unchanged.
- Latency: an op accepted at edge T with an empty FIFO gives result_valid_o=1 in the cycle after edge T+PipeStages-1, i.e. PipeStages cycles later.
- Throughput: 1 op/cycle when result_ready_i is held high.
- FIFO: result_*_o stay stable while result_valid_o=1 and result_ready_i=0. A simultaneous push and pop when full is impossible by the credit rule. Push and pop in the same cycle keep occupancy unchanged. Pointers wrap mod FifoDepth.
- busy_o = pipeline non-empty OR FIFO non-empty.

Test Plan:
- DOT signed, rs1=0x01020304, rs2=0x05060708 -> data=0x00000046, we=1, result_valid_o exactly 2 cycles after issue (PipeStages=2).
- DOT rs1=0xFFFFFFFF, rs2=0x02020202: signed_i=1 -> 0xFFFFFFF8; signed_i=0 -> 0x000007F8.
- Three back-to-back MACs to acc1 with the same operands as the first scenario -> results 0x46, 0x8C, 0xD2 on consecutive cycles. RDACC acc1 -> 0xD2; acc0 still 0.
- SETACC acc2=0x7FFFFFF0, then MAC rs1=rs2=0x7F7F7F7F: sat_i=1 -> 0x7FFFFFFF; repeat with sat_i=0 after re-SET -> 0x8000FBF4.
- Backpressure: result_ready_i=0, issue continuously -> issue_ready_o drops after 4 accepts (ids 0-3). Head is held stable. Releasing ready pops ids 0,1,2,3 in order; issue_ready_o reasserts the cycle after the first pop.
- Reset with 2 ops in flight and 1 queued -> no result_valid_o after reset, busy_o=0, RDACC of every accumulator returns 0.
